// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scan codes, state encodings and hit bit indices for the PS/2 arrow receiver
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    localparam int HIT_LEFT  = 0;
    localparam int HIT_UP    = 1;
    localparam int HIT_RIGHT = 2;
    localparam int HIT_DOWN  = 3;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SHIFT,
        FR_CHECK
    } frame_state_e;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_e;

    // One-hot key mask in hit_pulse bit order; zero for non-arrow codes.
    function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
        logic [3:0] mask;
        mask = 4'b0000;
        case (code)
            SC_LEFT:  mask[HIT_LEFT]  = 1'b1;
            SC_UP:    mask[HIT_UP]    = 1'b1;
            SC_RIGHT: mask[HIT_RIGHT] = 1'b1;
            SC_DOWN:  mask[HIT_DOWN]  = 1'b1;
            default:  mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 device-to-host frame deserializer with parity, stop and timeout checks
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TO_W           = 14
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_prev_q;
    logic            edge_q, bit_q;
    logic            fall;

    frame_state_e    state_q, state_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;

    assign fall = clk_prev_q & ~clk_sync_q[1];

    // Synchronizers idle high so leaving reset never fakes a falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            edge_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
            edge_q     <= fall;
            if (fall) begin
                bit_q <= dat_sync_q[1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FR_IDLE;
            bitcnt_q    <= 4'd0;
            shift_q     <= 10'd0;
            to_q        <= '0;
            rx_byte_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            to_q        <= to_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        to_d        = to_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            FR_IDLE: begin
                to_d = '0;
                if (edge_q) begin
                    if (!bit_q) begin
                        state_d  = FR_SHIFT;
                        bitcnt_d = 4'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            FR_SHIFT: begin
                if (edge_q) begin
                    to_d     = '0;
                    shift_d  = {bit_q, shift_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = FR_CHECK;
                    end
                end else if (to_q == TO_LAST) begin
                    // Counter would reach the limit this cycle: abandon the frame.
                    to_d        = '0;
                    frame_err_d = 1'b1;
                    state_d     = FR_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            FR_CHECK: begin
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    rx_byte_d  = shift_q[7:0];
                    rx_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                state_d = FR_IDLE;
            end
            default: state_d = FR_IDLE;
        endcase
    end

    assign rx_byte_o   = rx_byte_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_arrow_receiver.sv
// rtl/ps2_arrow_receiver.sv - PS/2 receiver top: extended arrow make/break decoder and key hit levels
module ps2_arrow_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TO_W           = 14
) (
    input  logic       CLOCK_50,
    input  logic       Reset_b,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       lefthit,
    output logic       uphit,
    output logic       righthit,
    output logic       downhit,
    output logic [3:0] hit_pulse
);

    dec_state_e dec_q, dec_d;
    logic [3:0] keys_q, keys_d;
    logic [3:0] pulse_q, pulse_d;
    logic [3:0] arrow;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_frame_rx (
        .clk_i       (CLOCK_50),
        .rst_ni      (Reset_b),
        .ps2_clk_i   (PS2_CLK),
        .ps2_dat_i   (PS2_DAT),
        .rx_byte_o   (rx_byte),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err)
    );

    assign arrow = arrow_onehot(rx_byte);

    always_ff @(posedge CLOCK_50 or negedge Reset_b) begin
        if (!Reset_b) begin
            dec_q   <= DEC_BASE;
            keys_q  <= 4'b0000;
            pulse_q <= 4'b0000;
        end else begin
            dec_q   <= dec_d;
            keys_q  <= keys_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        dec_d   = dec_q;
        keys_d  = keys_q;
        pulse_d = 4'b0000;
        if (frame_err) begin
            // A lost byte may have been part of a prefix; resynchronize.
            dec_d = DEC_BASE;
        end else if (rx_valid) begin
            case (dec_q)
                DEC_BASE: begin
                    if (rx_byte == SC_EXT) begin
                        dec_d = DEC_EXT;
                    end else if (rx_byte == SC_BRK) begin
                        dec_d = DEC_BRK;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte == SC_BRK) begin
                        dec_d = DEC_EXT_BRK;
                    end else if (rx_byte != SC_EXT) begin
                        // Typematic repeats keep the level without a fresh pulse.
                        pulse_d = arrow & ~keys_q;
                        keys_d  = keys_q | arrow;
                        dec_d   = DEC_BASE;
                    end
                end
                DEC_BRK: dec_d = DEC_BASE;
                DEC_EXT_BRK: begin
                    keys_d = keys_q & ~arrow;
                    dec_d  = DEC_BASE;
                end
                default: dec_d = DEC_BASE;
            endcase
        end
    end

    assign lefthit   = keys_q[HIT_LEFT];
    assign uphit     = keys_q[HIT_UP];
    assign righthit  = keys_q[HIT_RIGHT];
    assign downhit   = keys_q[HIT_DOWN];
    assign hit_pulse = pulse_q;

endmodule

// File: tb/tb_ps2_arrow_receiver.sv
// tb/tb_ps2_arrow_receiver.sv - directed self-checking bench for ps2_arrow_receiver
module tb_ps2_arrow_receiver;

    localparam int TO   = 200;
    localparam int HALF = 16;

    logic       CLOCK_50 = 1'b0;
    logic       Reset_b  = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_valid, frame_err;
    logic       lefthit, uphit, righthit, downhit;
    logic [3:0] hit_pulse;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_fall   = 0;
    int lvl_chg     = 0;
    logic [3:0] lvl_prev = 4'b0000;

    logic [7:0] rxb[$];
    int         rxc[$];
    int         errc[$];
    logic [3:0] hp[$];
    int         hc[$];

    ps2_arrow_receiver #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .CLOCK_50  (CLOCK_50),
        .Reset_b   (Reset_b),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .lefthit   (lefthit),
        .uphit     (uphit),
        .righthit  (righthit),
        .downhit   (downhit),
        .hit_pulse (hit_pulse)
    );

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (rx_valid) begin
            rxb.push_back(rx_byte);
            rxc.push_back(cyc);
        end
        if (frame_err) errc.push_back(cyc);
        if (hit_pulse != 4'b0000) begin
            hp.push_back(hit_pulse);
            hc.push_back(cyc);
        end
        if ({downhit, righthit, uphit, lefthit} != lvl_prev) begin
            lvl_chg  = cyc;
            lvl_prev = {downhit, righthit, uphit, lefthit};
        end
    end

    task automatic send_bits(input logic [7:0] d, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = f[i];
            repeat (HALF) @(negedge CLOCK_50);
            PS2_CLK   = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(negedge CLOCK_50);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input bit bad_par);
        send_bits(d, bad_par, 11);
        repeat (60) @(negedge CLOCK_50);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge CLOCK_50);
        vectors++;
        if ({rx_byte, rx_valid, frame_err, hit_pulse} !== 14'd0 || {lefthit, uphit, righthit, downhit} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_held: got byte=%h v=%b e=%b hp=%b lvl=%b want all 0", rx_byte, rx_valid, frame_err, hit_pulse, {lefthit, uphit, righthit, downhit});
        end
        Reset_b = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        vectors++;
        if ({rx_byte, rx_valid, frame_err, hit_pulse} !== 14'd0 || {lefthit, uphit, righthit, downhit} !== 4'd0 || errc.size() != 0) begin
            miscompares++;
            $display("FAIL reset_released: got byte=%h lvl=%b errs=%0d want all 0", rx_byte, {lefthit, uphit, righthit, downhit}, errc.size());
        end
    endtask

    task automatic test_left_make;
        int n0, h0;
        n0 = rxb.size();
        h0 = hp.size();
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b0);
        vectors++;
        if (rxb.size() != n0 + 2) begin
            miscompares++;
            $display("FAIL make_rx_count: got %0d want %0d", rxb.size() - n0, 2);
        end
        vectors++;
        if (rxb[n0] !== 8'hE0 || rxb[n0+1] !== 8'h6B) begin
            miscompares++;
            $display("FAIL make_rx_bytes: got %h %h want e0 6b", rxb[n0], rxb[n0+1]);
        end
        vectors++;
        if (rxc[$] != last_fall + 5) begin
            miscompares++;
            $display("FAIL make_rx_latency: got %0d want %0d", rxc[$] - last_fall, 5);
        end
        vectors++;
        if (lefthit !== 1'b1 || {uphit, righthit, downhit} !== 3'b000) begin
            miscompares++;
            $display("FAIL make_levels: got %b want 0001", {downhit, righthit, uphit, lefthit});
        end
        vectors++;
        if (hp.size() != h0 + 1 || hp[h0] !== 4'b0001 || hc[h0] != rxc[$] + 1) begin
            miscompares++;
            $display("FAIL make_pulse: got n=%0d hp=%b dt=%0d want n=1 hp=0001 dt=1", hp.size() - h0, hp[h0], hc[h0] - rxc[$]);
        end
    endtask

    task automatic test_typematic_break;
        int h0;
        h0 = hp.size();
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b0);
        vectors++;
        if (hp.size() != h0 || lefthit !== 1'b1) begin
            miscompares++;
            $display("FAIL repeat_no_pulse: got pulses=%0d left=%b want 0 1", hp.size() - h0, lefthit);
        end
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h6B, 1'b0);
        vectors++;
        if (lefthit !== 1'b0 || lvl_chg != rxc[$] + 1) begin
            miscompares++;
            $display("FAIL break_release: got left=%b dt=%0d want 0 1", lefthit, lvl_chg - rxc[$]);
        end
        vectors++;
        if (hp.size() != h0) begin
            miscompares++;
            $display("FAIL break_no_pulse: got %0d want 0", hp.size() - h0);
        end
    endtask

    task automatic test_multi_key;
        int h0;
        h0 = hp.size();
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h72, 1'b0);
        vectors++;
        if ({downhit, righthit, uphit, lefthit} !== 4'b1010) begin
            miscompares++;
            $display("FAIL multi_levels: got %b want 1010", {downhit, righthit, uphit, lefthit});
        end
        vectors++;
        if (hp.size() != h0 + 2 || hp[h0] !== 4'b0010 || hp[h0+1] !== 4'b1000 || hc[h0+1] != rxc[$] + 1) begin
            miscompares++;
            $display("FAIL multi_pulses: got n=%0d %b %b dt=%0d want n=2 0010 1000 dt=1", hp.size() - h0, hp[h0], hp[h0+1], hc[h0+1] - rxc[$]);
        end
        send(8'h75, 1'b0);
        vectors++;
        if ({downhit, righthit, uphit, lefthit} !== 4'b1010 || hp.size() != h0 + 2 || rxb[$] !== 8'h75) begin
            miscompares++;
            $display("FAIL bare_code_ignored: got lvl=%b pulses=%0d byte=%h want 1010 2 75", {downhit, righthit, uphit, lefthit}, hp.size() - h0, rxb[$]);
        end
    endtask

    task automatic test_parity_err;
        int e0, r0, h0;
        e0 = errc.size();
        r0 = rxb.size();
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b1);
        vectors++;
        if (errc.size() != e0 + 1 || rxb.size() != r0 + 1 || errc[$] != last_fall + 5) begin
            miscompares++;
            $display("FAIL parity_err: got errs=%0d rx=%0d dt=%0d want 1 1 5", errc.size() - e0, rxb.size() - r0, errc[$] - last_fall);
        end
        h0 = hp.size();
        send(8'h6B, 1'b0);
        vectors++;
        if (lefthit !== 1'b0 || hp.size() != h0) begin
            miscompares++;
            $display("FAIL parity_dec_base: got left=%b pulses=%0d want 0 0", lefthit, hp.size() - h0);
        end
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b0);
        vectors++;
        if (lefthit !== 1'b1 || hp.size() != h0 + 1 || hp[$] !== 4'b0001) begin
            miscompares++;
            $display("FAIL parity_recover: got left=%b pulses=%0d hp=%b want 1 1 0001", lefthit, hp.size() - h0, hp[$]);
        end
    endtask

    task automatic test_timeout;
        int e0, fall0;
        e0 = errc.size();
        send_bits(8'hE0, 1'b0, 5);
        fall0 = last_fall;
        repeat (TO + 50) @(negedge CLOCK_50);
        vectors++;
        if (errc.size() != e0 + 1 || errc[$] != fall0 + TO + 4) begin
            miscompares++;
            $display("FAIL timeout_err: got errs=%0d dt=%0d want 1 %0d", errc.size() - e0, errc[$] - fall0, TO + 4);
        end
        send(8'h75, 1'b0);
        vectors++;
        if (rxb[$] !== 8'h75 || rxc[$] != last_fall + 5 || errc.size() != e0 + 1) begin
            miscompares++;
            $display("FAIL timeout_recover: got byte=%h dt=%0d errs=%0d want 75 5 1", rxb[$], rxc[$] - last_fall, errc.size() - e0);
        end
    endtask

    task automatic test_async_reset;
        int e0, h0;
        e0 = errc.size();
        send_bits(8'hE0, 1'b0, 6);
        repeat (5) @(negedge CLOCK_50);
        #3;
        Reset_b = 1'b0;
        #1;
        vectors++;
        if ({lefthit, uphit, righthit, downhit} !== 4'd0 || rx_byte !== 8'd0 || {rx_valid, frame_err, hit_pulse} !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset: got lvl=%b byte=%h v=%b e=%b hp=%b want all 0", {lefthit, uphit, righthit, downhit}, rx_byte, rx_valid, frame_err, hit_pulse);
        end
        repeat (4) @(negedge CLOCK_50);
        Reset_b = 1'b1;
        repeat (TO + 50) @(negedge CLOCK_50);
        vectors++;
        if (errc.size() != e0) begin
            miscompares++;
            $display("FAIL reset_no_err: got %0d want 0", errc.size() - e0);
        end
        h0 = hp.size();
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b0);
        vectors++;
        if ({downhit, righthit, uphit, lefthit} !== 4'b0001 || hp.size() != h0 + 1 || hp[$] !== 4'b0001) begin
            miscompares++;
            $display("FAIL post_reset_make: got lvl=%b pulses=%0d hp=%b want 0001 1 0001", {downhit, righthit, uphit, lefthit}, hp.size() - h0, hp[$]);
        end
    endtask

    initial begin
        test_reset;
        test_left_make;
        test_typematic_break;
        test_multi_key;
        test_parity_err;
        test_timeout;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
